// File: rtl/snes_controller_emulator.sv
// SNES game-pad emulator: answers the console's latch/clock poll with the 16-bit
// serial button frame, with both console lines synchronized into the clk domain.
module snes_controller_emulator #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_data_latch,
    input  logic        i_data_clk,
    input  logic [11:0] i_button_state,
    input  logic        i_connected,
    output logic        o_serial_out,
    output logic        o_busy,
    output logic        o_poll_strobe
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic [SYNC_STAGES-1:0] r_dclk_sync;
    logic                   r_latch_prev;
    logic                   r_dclk_prev;

    state_t                 r_state;
    logic [15:0]            r_shift_reg;
    logic [4:0]             r_bit_cnt;
    logic [TMO_W-1:0]       r_tmo_cnt;
    logic                   r_serial_out;
    logic                   r_busy;
    logic                   r_poll_strobe;

    logic                   w_latch_s;
    logic                   w_dclk_s;
    logic                   w_latch_rise;
    logic                   w_latch_fall;
    logic                   w_dclk_rise;
    logic [15:0]            w_load_val;
    state_t                 w_state_nxt;
    logic [15:0]            w_shift_nxt;
    logic [4:0]             w_bit_cnt_nxt;
    logic [TMO_W-1:0]       w_tmo_nxt;
    logic                   w_strobe;

    // Synchronizers reset to idle line levels so reset release never fakes an edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_latch_sync <= {SYNC_STAGES{1'b0}};
            r_dclk_sync  <= {SYNC_STAGES{1'b1}};
            r_latch_prev <= 1'b0;
            r_dclk_prev  <= 1'b1;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_data_latch};
            r_dclk_sync  <= {r_dclk_sync[SYNC_STAGES-2:0], i_data_clk};
            r_latch_prev <= w_latch_s;
            r_dclk_prev  <= w_dclk_s;
        end
    end

    assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
    assign w_dclk_s     = r_dclk_sync[SYNC_STAGES-1];
    assign w_latch_rise = w_latch_s & ~r_latch_prev;
    assign w_latch_fall = ~w_latch_s & r_latch_prev;
    assign w_dclk_rise  = w_dclk_s & ~r_dclk_prev;
    // Line levels: pressed drives low, the four trailing ID bits idle high
    assign w_load_val   = {4'b1111, ~i_button_state};

    // Next-state and datapath decode; a latch rising edge overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift_reg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tmo_nxt     = r_tmo_cnt;
        w_strobe      = 1'b0;
        if (w_latch_rise) begin
            w_state_nxt   = ST_LATCH;
            w_shift_nxt   = w_load_val;
            w_bit_cnt_nxt = 5'd0;
            w_tmo_nxt     = {TMO_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_shift_nxt = 16'h0000;
                end
                ST_LATCH: begin
                    if (w_latch_fall) begin
                        w_state_nxt = ST_SHIFT;
                        w_strobe    = 1'b1;
                        w_tmo_nxt   = {TMO_W{1'b0}};
                    end else begin
                        w_shift_nxt = w_load_val;
                    end
                end
                ST_SHIFT: begin
                    if (w_dclk_rise) begin
                        w_shift_nxt   = {1'b0, r_shift_reg[15:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        w_tmo_nxt     = {TMO_W{1'b0}};
                        if (r_bit_cnt == 5'd15) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_SHIFT;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_shift_nxt = 16'h0000;
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    w_shift_nxt = 16'h0000;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_shift_nxt = 16'h0000;
                end
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_shift_reg   <= 16'h0000;
            r_bit_cnt     <= 5'd0;
            r_tmo_cnt     <= {TMO_W{1'b0}};
            r_serial_out  <= 1'b0;
            r_busy        <= 1'b0;
            r_poll_strobe <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift_reg   <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_tmo_cnt     <= w_tmo_nxt;
            r_serial_out  <= w_shift_nxt[0] & i_connected;
            r_busy        <= (w_state_nxt == ST_LATCH) || (w_state_nxt == ST_SHIFT);
            r_poll_strobe <= w_strobe;
        end
    end

    assign o_serial_out  = r_serial_out;
    assign o_busy        = r_busy;
    assign o_poll_strobe = r_poll_strobe;

endmodule

// File: tb/tb_snes_controller_emulator.sv
// Directed bench for snes_controller_emulator: per-frame expected serial bits are
// queued when the latch is driven and popped as each bit is sampled.
module tb_snes_controller_emulator;

    localparam int SYNC = 2;
    localparam int TMO  = 2000;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        data_latch = 1'b0;
    logic        data_clk   = 1'b1;
    logic        connected  = 1'b1;
    logic [11:0] buttons    = 12'h000;
    logic        serial_out;
    logic        busy;
    logic        poll_strobe;

    int   total      = 0;
    int   bad        = 0;
    int   strobe_cnt = 0;
    logic exp_q[$];

    snes_controller_emulator #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_data_latch   (data_latch),
        .i_data_clk     (data_clk),
        .i_button_state (buttons),
        .i_connected    (connected),
        .o_serial_out   (serial_out),
        .o_busy         (busy),
        .o_poll_strobe  (poll_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (poll_strobe) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        check(tag, {31'd0, serial_out}, {31'd0, e});
    endtask

    task automatic run_frame(input logic [11:0] btn, input logic [11:0] btn_mid,
                             input logic conn, input int half, input int nclk,
                             input string tag);
        logic [15:0] line;
        int          s0;
        line = {4'hF, ~btn};
        for (int k = 0; k <= nclk; k++)
            exp_q.push_back((k < 16) ? (conn & line[k]) : 1'b0);
        buttons    = btn;
        connected  = conn;
        s0         = strobe_cnt;
        data_latch = 1'b1;
        data_clk   = 1'b1;
        cyc(2 * half);
        check({tag, "_busy_latch"}, {31'd0, busy}, 32'd1);
        data_latch = 1'b0;
        cyc(SYNC + 3);
        buttons = btn_mid;
        check({tag, "_strobe"}, strobe_cnt - s0, 32'd1);
        check({tag, "_busy_shift"}, {31'd0, busy}, 32'd1);
        cyc(half);
        pop_check({tag, "_b0"});
        for (int i = 1; i <= nclk; i++) begin
            data_clk = 1'b0;
            cyc(half);
            data_clk = 1'b1;
            cyc(half);
            pop_check($sformatf("%s_b%0d", tag, i));
        end
        if (nclk == 16) check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int s0;
        // Reset state
        cyc(5);
        check("rst_serial", {31'd0, serial_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobe", {31'd0, poll_strobe}, 32'd0);
        rst = 1'b0;
        cyc(10);
        check("rel_no_strobe", strobe_cnt, 32'd0);
        check("rel_busy", {31'd0, busy}, 32'd0);

        // B only at console timing, then a 17th clock in DONE
        run_frame(12'h001, 12'h001, 1'b1, 600, 16, "fB");
        data_clk = 1'b0;
        cyc(600);
        data_clk = 1'b1;
        cyc(600);
        check("done_17th_serial", {31'd0, serial_out}, 32'd0);
        check("done_17th_busy", {31'd0, busy}, 32'd0);

        run_frame(12'hFFF, 12'hFFF, 1'b1, 6, 16, "fAll");
        run_frame(12'hFFF, 12'hFFF, 1'b0, 6, 16, "fDisc");
        // Buttons change mid-frame must not leak into the shifted data
        run_frame(12'hA5C, 12'h3A3, 1'b1, 6, 16, "fMid");

        // Abort after 5 clocks; new latch rises together with data_clk
        run_frame(12'h010, 12'h010, 1'b1, 6, 5, "fAbort");
        data_clk = 1'b0;
        cyc(6);
        run_frame(12'h800, 12'h800, 1'b1, 6, 16, "fRestart");

        // Timeout after 3 clocks of silence
        run_frame(12'h0C3, 12'h0C3, 1'b1, 6, 3, "fTmo");
        cyc(TMO - 100);
        check("tmo_before_busy", {31'd0, busy}, 32'd1);
        cyc(200);
        check("tmo_after_busy", {31'd0, busy}, 32'd0);
        check("tmo_after_serial", {31'd0, serial_out}, 32'd0);
        data_clk = 1'b0;
        cyc(6);
        data_clk = 1'b1;
        cyc(6);
        check("tmo_extra_clk_serial", {31'd0, serial_out}, 32'd0);

        // Reset at bit 7 of a frame
        run_frame(12'h30C, 12'h30C, 1'b1, 6, 7, "fRst");
        rst = 1'b1;
        cyc(1);
        check("midrst_serial", {31'd0, serial_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_strobe", {31'd0, poll_strobe}, 32'd0);
        cyc(3);
        rst = 1'b0;
        s0 = strobe_cnt;
        cyc(10);
        check("midrst_no_strobe", strobe_cnt - s0, 32'd0);
        check("midrst_rel_busy", {31'd0, busy}, 32'd0);
        run_frame(12'h555, 12'h555, 1'b1, 6, 16, "fFresh");

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
